// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversampling
// constants and the baud divider calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_W = 8;
    localparam int UART_OS     = 16;
    localparam int SAMPLE_T0   = 7;
    localparam int SAMPLE_T1   = 8;
    localparam int SAMPLE_T2   = 9;

    // Clock cycles per oversample tick, integer floor.
    function automatic int baud_div(input int clk_hz, input int baud, input int os = UART_OS);
        return clk_hz / (baud * os);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the wrap cycle.
// A synchronous clear holds the count at zero.
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter, cleared by reset or by the idle receiver.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampled 8N1 UART receiver with majority-vote sampling, a valid/ready
// holding register and one-cycle framing/overrun error pulses.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    input  logic                   rx_ready,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam logic [3:0] T0     = 4'(SAMPLE_T0);
    localparam logic [3:0] T1     = 4'(SAMPLE_T1);
    localparam logic [3:0] T2     = 4'(SAMPLE_T2);
    localparam logic [3:0] T_LAST = 4'(UART_OS - 1);

    uart_state_t state, state_nxt;

    logic                   sync1;
    logic                   rxd_s;
    logic [3:0]             tcnt;
    logic [2:0]             bit_idx;
    logic                   samp0;
    logic                   samp1;
    logic [UART_DATA_W-1:0] shift;
    logic                   armed;
    logic                   tick;
    logic                   vote;
    logic                   shift_en;
    logic                   byte_done;
    logic                   frame_bad;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign vote = maj3(samp0, samp1, rxd_s);

    // Two-flop synchronizer on the asynchronous line, idle-high at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rxd_s) begin
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                if (tick && (tcnt == T2) && vote) begin
                    state_nxt = IDLE;
                end else if (tick && (tcnt == T_LAST)) begin
                    state_nxt = DATA;
                end else begin
                    state_nxt = START;
                end
            end
            DATA: begin
                if (tick && (tcnt == T2)) begin
                    shift_en = 1'b1;
                end else begin
                    shift_en = 1'b0;
                end
                if (tick && (tcnt == T_LAST) && (bit_idx == 3'd7)) begin
                    state_nxt = STOP;
                end else begin
                    state_nxt = DATA;
                end
            end
            STOP: begin
                // Leave at mid-stop so a start edge in the last half bit is caught.
                if (tick && (tcnt == T2)) begin
                    state_nxt = IDLE;
                    byte_done = vote;
                    frame_bad = !vote;
                end else begin
                    state_nxt = STOP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Oversample position, bit index, vote samples and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt    <= 4'd0;
            bit_idx <= 3'd0;
            samp0   <= 1'b1;
            samp1   <= 1'b1;
            shift   <= '0;
        end else begin
            if (state == IDLE) begin
                tcnt <= 4'd0;
            end else if (tick) begin
                tcnt <= tcnt + 4'd1;
            end
            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (tick && (tcnt == T_LAST)) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (tick && (tcnt == T0)) begin
                samp0 <= rxd_s;
            end
            if (tick && (tcnt == T1)) begin
                samp1 <= rxd_s;
            end
            if (shift_en) begin
                shift <= {vote, shift[UART_DATA_W-1:1]};
            end
        end
    end

    // A break line must return high before another start edge is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
        end else if (frame_bad) begin
            armed <= 1'b0;
        end else if (rxd_s) begin
            armed <= 1'b1;
        end
    end

    // Holding register with handshake and registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= byte_done && rx_valid && !rx_ready;
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at DIV=10 (160 clocks per bit).
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int BIT_CLKS = 160;
    localparam int STOP_LAT = 1543;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int start_cyc = 0;

    logic       valid_q = 1'b0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    int         hs_cnt = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] hs_data [0:15];

    int hs_base, rise_base, fe_base, ov_base;

    uart_rx_os #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes and error pulses away from the active edge.
    always @(negedge clk) begin
        valid_q <= rx_valid;
        if (rx_valid && !valid_q) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (rx_valid && rx_ready) begin
            hs_data[hs_cnt[3:0]] <= rx_data;
            hs_cnt <= hs_cnt + 1;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic mark();
        hs_base   = hs_cnt;
        rise_base = rise_cnt;
        fe_base   = fe_cnt;
        ov_base   = ov_cnt;
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b1;
        wait_clks(3);
        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_ovr", 32'(overrun), 32'h0);
        rst = 1'b0;
        wait_clks(20);

        // Single byte with latency check.
        mark();
        send_byte(8'h55, 1'b1);
        wait_clks(20);
        check("b55_hs", 32'(hs_cnt - hs_base), 32'd1);
        check("b55_data", 32'(hs_data[hs_base[3:0]]), 32'h55);
        check("b55_latency", 32'(rise_cyc - start_cyc), 32'(STOP_LAT));
        check("b55_ferr", 32'(fe_cnt - fe_base), 32'd0);
        check("b55_ovr", 32'(ov_cnt - ov_base), 32'd0);

        // Back-to-back frames with a single stop bit.
        mark();
        send_byte(8'hA3, 1'b1);
        send_byte(8'h0F, 1'b1);
        wait_clks(20);
        check("b2b_hs", 32'(hs_cnt - hs_base), 32'd2);
        check("b2b_data0", 32'(hs_data[hs_base[3:0]]), 32'hA3);
        check("b2b_data1", 32'(hs_data[4'(hs_base + 1)]), 32'h0F);
        check("b2b_flags", 32'((fe_cnt - fe_base) + (ov_cnt - ov_base)), 32'd0);

        // Short low glitch is rejected by the start-bit vote.
        mark();
        rxd = 1'b0;
        wait_clks(40);
        rxd = 1'b1;
        wait_clks(200);
        check("glitch_rise", 32'(rise_cnt - rise_base), 32'd0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_flags", 32'((fe_cnt - fe_base) + (ov_cnt - ov_base)), 32'd0);

        // Framing error, then recovery.
        mark();
        send_byte(8'h3C, 1'b0);
        rxd = 1'b1;
        wait_clks(100);
        check("fe_pulse", 32'(fe_cnt - fe_base), 32'd1);
        check("fe_rise", 32'(rise_cnt - rise_base), 32'd0);
        mark();
        send_byte(8'h41, 1'b1);
        wait_clks(20);
        check("fe_next_hs", 32'(hs_cnt - hs_base), 32'd1);
        check("fe_next_data", 32'(hs_data[hs_base[3:0]]), 32'h41);

        // Overrun while the consumer stalls.
        mark();
        rx_ready = 1'b0;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_clks(20);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_data", 32'(rx_data), 32'h12);
        check("ovr_pulse", 32'(ov_cnt - ov_base), 32'd1);
        check("ovr_no_hs", 32'(hs_cnt - hs_base), 32'd0);
        rx_ready = 1'b1;
        wait_clks(1);
        check("ovr_drop", 32'(rx_valid), 32'h0);
        check("ovr_keep", 32'(rx_data), 32'h12);
        check("ovr_hs", 32'(hs_data[hs_base[3:0]]), 32'h12);

        // Reset in the middle of a 0xFF frame.
        mark();
        rxd = 1'b0;
        wait_clks(BIT_CLKS);
        rxd = 1'b1;
        wait_clks(400);
        rst = 1'b1;
        wait_clks(1);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        wait_clks(1200);
        send_byte(8'h81, 1'b1);
        wait_clks(20);
        check("rst_hs", 32'(hs_cnt - hs_base), 32'd1);
        check("rst_next_data", 32'(hs_data[hs_base[3:0]]), 32'h81);
        check("rst_ferr_cnt", 32'(fe_cnt - fe_base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
